// File: rtl/conv_run_sequencer.sv
// -----------------------------------------------------------------------------
// conv_run_sequencer
//
// Sequences the 2D-convolution datapath for one image frame.
//   LOAD   : host i_valid pulses become line-buffer write addresses 0..L-1.
//   STREAM : one line-buffer column read per cycle, addresses 0..L-1.
//   DRAIN  : waits for the convolution pipeline to flush its last result.
//   DONE   : o_EOP held until the next i_load.
//
// Result write-back: every read is tagged with its column index k and carried
// alongside the convolution core latency. Columns 0 and 1 only prime the
// kernel window, so column k writes result address k-2.
//
// Optional feature (macro SEQ_CYCLE_CNT_EN): adds o_run_cycles, a saturating
// 16-bit count of the cycles spent streaming and draining the last frame.
//
// Ports
//   i_CLK          system clock
//   i_rst          synchronous active-high reset
//   i_load         load mode level
//   i_run          run request level (held until EOP)
//   i_valid        single-cycle pulse: new column word on the write data
//   i_imgLength    image width L in columns
//   o_wr_en/addr   line-buffer write strobe / address
//   o_rd_en/addr   line-buffer read strobe / address (memory has 1-cycle latency)
//   o_conv_valid   read data valid at the convolution core input
//   o_res_wr_en    result memory write strobe
//   o_res_addr     result memory address
//   o_EOP          frame done, sticky until next load
//   o_err          sticky: load overflow, or L<3 at run
//   o_run_cycles   (SEQ_CYCLE_CNT_EN only) streaming cycle count
// -----------------------------------------------------------------------------
module conv_run_sequencer #(
    parameter int NB_ADDR  = 10,
    parameter int CONV_LAT = 2      // legal range 1..7
) (
    input  logic               i_CLK,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_run,
    input  logic               i_valid,
    input  logic [NB_ADDR-1:0] i_imgLength,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic               o_rd_en,
    output logic [NB_ADDR-1:0] o_rd_addr,
    output logic               o_conv_valid,
    output logic               o_res_wr_en,
    output logic [NB_ADDR-1:0] o_res_addr,
    output logic               o_EOP,
    output logic               o_err
`ifdef SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]        o_run_cycles
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [NB_ADDR-1:0] C_ONE   = NB_ADDR'(1);
    localparam logic [NB_ADDR-1:0] C_TWO   = NB_ADDR'(2);
    localparam logic [NB_ADDR-1:0] C_THREE = NB_ADDR'(3);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_load_start;
    logic                 w_issue_rd;
    logic                 w_short;
    logic                 w_err_clr;
    logic                 w_stream_entry;
    logic                 w_wr_req;
    logic                 w_pipe_busy;
    logic                 w_res_hit;

    logic [NB_ADDR-1:0]   r_load_cnt;
    logic                 r_load_full;
    logic                 r_wr_en;
    logic [NB_ADDR-1:0]   r_wr_addr;
    logic [NB_ADDR-1:0]   r_len;
    logic [NB_ADDR-1:0]   r_rd_cnt;
    logic                 r_rd_en;
    logic [NB_ADDR-1:0]   r_rd_addr;
    logic                 r_conv_valid;
    logic [NB_ADDR-1:0]   r_conv_k;
    logic                 r_err;
    logic [CONV_LAT-1:0]  r_sh_v;
    logic [NB_ADDR-1:0]   r_sh_k [CONV_LAT];

    // ---------------- next-state / control ----------------
    always_comb begin
        w_state_next = r_state;
        w_load_start = 1'b0;
        w_issue_rd   = 1'b0;
        w_short      = 1'b0;
        w_err_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_state_next = ST_LOAD;
                    w_load_start = 1'b1;
                end else if (i_run) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_LOAD: begin
                if (i_run)        w_state_next = ST_STREAM;
                else if (!i_load) w_state_next = ST_IDLE;
            end
            ST_STREAM: begin
                // r_len was captured on entry, so it is stable here.
                if (r_len < C_THREE) begin
                    w_state_next = ST_DONE;
                    w_short      = 1'b1;
                end else begin
                    w_issue_rd = 1'b1;
                    if (r_rd_cnt == r_len - C_ONE) w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last pipeline stage may be writing right now; that write
                // completes in this cycle, so EOP rises strictly after it.
                if (!w_pipe_busy) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (i_load) begin
                    w_state_next = ST_LOAD;
                    w_load_start = 1'b1;
                    w_err_clr    = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_stream_entry = (w_state_next == ST_STREAM) && (r_state != ST_STREAM);
    assign w_wr_req       = (r_state == ST_LOAD) && i_valid;

    // Anything still in flight ahead of the final shift-register stage.
    always_comb begin
        w_pipe_busy = r_rd_en | r_conv_valid;
        for (int i = 0; i < CONV_LAT - 1; i++) begin
            w_pipe_busy = w_pipe_busy | r_sh_v[i];
        end
    end

    // ---------------- sequential state ----------------
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_load_cnt   <= '0;
            r_load_full  <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_len        <= '0;
            r_rd_cnt     <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_conv_valid <= 1'b0;
            r_conv_k     <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Load side: write at the counter, saturating at L-1.
            r_wr_en <= 1'b0;
            if (w_load_start) begin
                r_load_cnt  <= '0;
                r_load_full <= 1'b0;
            end else if (w_wr_req) begin
                if (!r_load_full) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_load_cnt;
                    if (r_load_cnt == i_imgLength - C_ONE) r_load_full <= 1'b1;
                    else                                   r_load_cnt  <= r_load_cnt + C_ONE;
                end
            end

            // Stream side.
            if (w_stream_entry) begin
                r_len    <= i_imgLength;
                r_rd_cnt <= '0;
            end
            r_rd_en <= w_issue_rd;
            if (w_issue_rd) begin
                r_rd_addr <= r_rd_cnt;
                r_rd_cnt  <= r_rd_cnt + C_ONE;
            end
            r_conv_valid <= r_rd_en;
            r_conv_k     <= r_rd_addr;

            if (w_err_clr)
                r_err <= 1'b0;
            else if (w_short || (w_wr_req && r_load_full && !w_load_start))
                r_err <= 1'b1;
        end
    end

    // ---------------- latency-matching tag pipeline ----------------
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            r_sh_v[0] <= 1'b0;
            r_sh_k[0] <= '0;
        end else begin
            r_sh_v[0] <= r_conv_valid;
            r_sh_k[0] <= r_conv_k;
        end
    end

    generate
        for (genvar gi = 1; gi < CONV_LAT; gi++) begin : g_tag_stage
            always_ff @(posedge i_CLK) begin
                if (i_rst) begin
                    r_sh_v[gi] <= 1'b0;
                    r_sh_k[gi] <= '0;
                end else begin
                    r_sh_v[gi] <= r_sh_v[gi-1];
                    r_sh_k[gi] <= r_sh_k[gi-1];
                end
            end
        end
    endgenerate

    // Columns 0 and 1 are window fill; subtraction only happens for k>=2.
    assign w_res_hit = r_sh_v[CONV_LAT-1] && (r_sh_k[CONV_LAT-1] >= C_TWO);

`ifdef SEQ_CYCLE_CNT_EN
    logic [15:0] r_run_cycles;
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            r_run_cycles <= '0;
        end else if (w_stream_entry) begin
            r_run_cycles <= '0;
        end else if ((r_state == ST_STREAM || r_state == ST_DRAIN) &&
                     (w_state_next == ST_STREAM || w_state_next == ST_DRAIN) &&
                     (r_run_cycles != 16'hFFFF)) begin
            r_run_cycles <= r_run_cycles + 16'd1;
        end
    end
    assign o_run_cycles = r_run_cycles;
`endif

    // ---------------- outputs ----------------
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_rd_en      = r_rd_en;
    assign o_rd_addr    = r_rd_addr;
    assign o_conv_valid = r_conv_valid;
    assign o_res_wr_en  = w_res_hit;
    assign o_res_addr   = w_res_hit ? (r_sh_k[CONV_LAT-1] - C_TWO) : '0;
    assign o_EOP        = (r_state == ST_DONE);
    assign o_err        = r_err;

endmodule

// File: tb/tb_conv_run_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for conv_run_sequencer (NB_ADDR=10, CONV_LAT=2).
// Expected strobes (address + cycle) are queued when stimulus is driven and
// popped by a negedge monitor whenever the DUT raises the matching strobe.
// -----------------------------------------------------------------------------
module tb_conv_run_sequencer;

    localparam int NB  = 10;
    localparam int LAT = 2;

    logic          i_CLK = 1'b0;
    logic          i_rst;
    logic          i_load;
    logic          i_run;
    logic          i_valid;
    logic [NB-1:0] i_imgLength;
    logic          o_wr_en;
    logic [NB-1:0] o_wr_addr;
    logic          o_rd_en;
    logic [NB-1:0] o_rd_addr;
    logic          o_conv_valid;
    logic          o_res_wr_en;
    logic [NB-1:0] o_res_addr;
    logic          o_EOP;
    logic          o_err;
`ifdef SEQ_CYCLE_CNT_EN
    logic [15:0]   o_run_cycles;
`endif

    conv_run_sequencer #(.NB_ADDR(NB), .CONV_LAT(LAT)) dut (
        .i_CLK        (i_CLK),
        .i_rst        (i_rst),
        .i_load       (i_load),
        .i_run        (i_run),
        .i_valid      (i_valid),
        .i_imgLength  (i_imgLength),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .o_conv_valid (o_conv_valid),
        .o_res_wr_en  (o_res_wr_en),
        .o_res_addr   (o_res_addr),
        .o_EOP        (o_EOP),
        .o_err        (o_err)
`ifdef SEQ_CYCLE_CNT_EN
        ,
        .o_run_cycles (o_run_cycles)
`endif
    );

    always #5 i_CLK = ~i_CLK;

    int cyc = 0;
    always @(posedge i_CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [NB-1:0] addr;
        int            cyc;
    } ev_t;

    ev_t wr_q[$];
    ev_t rd_q[$];
    ev_t cv_q[$];
    ev_t res_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One i_valid pulse; the write (if expected) appears the cycle after sampling.
    task automatic load_pulse(input int addr, input bit expect_wr);
        ev_t e;
        i_valid = 1'b1;
        if (expect_wr) begin
            e.addr = NB'(addr);
            e.cyc  = cyc + 1;
            wr_q.push_back(e);
        end
        step();
        i_valid = 1'b0;
        step();
    endtask

    // Queue the strobes of a run whose i_run is about to be sampled at edge E0.
    task automatic push_run(input int n_rd, input int n_cv, input int last_res_k, output int e0);
        ev_t e;
        e0 = cyc + 1;
        for (int k = 0; k < n_rd; k++) begin
            e.addr = NB'(k); e.cyc = e0 + 1 + k; rd_q.push_back(e);
        end
        for (int k = 0; k < n_cv; k++) begin
            e.addr = NB'(k); e.cyc = e0 + 2 + k; cv_q.push_back(e);
        end
        for (int k = 2; k <= last_res_k; k++) begin
            e.addr = NB'(k - 2); e.cyc = e0 + 2 + k + LAT; res_q.push_back(e);
        end
    endtask

    task automatic wait_eop(input int exp_cyc, input string tag);
        int n = 0;
        while (!o_EOP && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_seen"}, o_EOP, 1);
        chk({tag, "_cycle"}, cyc, exp_cyc);
    endtask

    // Strobe monitor: each strobe must match the head of its queue.
    always @(negedge i_CLK) begin
        ev_t e;
        if (o_wr_en) begin
            chk("wr_expected", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) begin
                e = wr_q.pop_front();
                chk("wr_addr", o_wr_addr, e.addr);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
        if (o_rd_en) begin
            chk("rd_expected", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                chk("rd_addr", o_rd_addr, e.addr);
                chk("rd_cycle", cyc, e.cyc);
            end
        end
        if (o_conv_valid) begin
            chk("cv_expected", cv_q.size() > 0, 1);
            if (cv_q.size() > 0) begin
                e = cv_q.pop_front();
                chk("cv_cycle", cyc, e.cyc);
            end
        end
        if (o_res_wr_en) begin
            chk("res_expected", res_q.size() > 0, 1);
            chk("res_not_with_eop", o_EOP, 0);
            if (res_q.size() > 0) begin
                e = res_q.pop_front();
                chk("res_addr", o_res_addr, e.addr);
                chk("res_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int e0;
        i_rst = 1'b1; i_load = 1'b0; i_run = 1'b0; i_valid = 1'b0; i_imgLength = '0;
        steps(3);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_wr_addr", o_wr_addr, 0);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_rd_addr", o_rd_addr, 0);
        chk("rst_conv_valid", o_conv_valid, 0);
        chk("rst_res_wr_en", o_res_wr_en, 0);
        chk("rst_res_addr", o_res_addr, 0);
        chk("rst_eop", o_EOP, 0);
        chk("rst_err", o_err, 0);
        i_rst = 1'b0;
        steps(3);
        chk("idle_eop", o_EOP, 0);

        // Load 8 columns.
        i_imgLength = NB'(8);
        i_load = 1'b1;
        step();
        for (int a = 0; a < 8; a++) load_pulse(a, 1'b1);
        chk("load8_err", o_err, 0);
        chk("load8_all_written", wr_q.size(), 0);
        i_load = 1'b0;
        step();

        // Full run, L=8.
        push_run(8, 8, 7, e0);
        i_run = 1'b1;
        wait_eop(e0 + 8 + LAT + 2, "run8_eop");
        chk("run8_err", o_err, 0);
`ifdef SEQ_CYCLE_CNT_EN
        chk("run8_cycles", o_run_cycles, 11);
`endif
        chk("run8_rd_left", rd_q.size(), 0);
        chk("run8_res_left", res_q.size(), 0);

        // i_run still high in DONE: no new frame.
        steps(5);
        chk("done_hold_eop", o_EOP, 1);
        chk("done_no_rd", rd_q.size(), 0);
        i_run = 1'b0;
        i_load = 1'b1;
        step();
        chk("load_drops_eop", o_EOP, 0);

        // Overflow: L=4, 6 pulses.
        i_imgLength = NB'(4);
        for (int a = 0; a < 6; a++) load_pulse(a, a < 4);
        chk("ovf_err", o_err, 1);
        chk("ovf_writes", wr_q.size(), 0);

        // Run wins over load when both high.
        push_run(4, 4, 3, e0);
        i_run = 1'b1;
        step();
        i_load = 1'b0;
        wait_eop(e0 + 4 + LAT + 2, "run4_eop");
        chk("run4_err_sticky", o_err, 1);
        i_run = 1'b0;
        i_load = 1'b1;
        step();
        chk("run4_load_clr_err", o_err, 0);
        chk("run4_load_clr_eop", o_EOP, 0);

        // Short image: L=2.
        i_imgLength = NB'(2);
        i_load = 1'b0;
        i_run = 1'b1;
        step();
        step();
        chk("short_eop", o_EOP, 1);
        chk("short_err", o_err, 1);
        steps(2);
        i_run = 1'b0;
        i_load = 1'b1;
        step();
        i_load = 1'b0;
        step();
        chk("short_err_cleared", o_err, 0);

        // Reset while column 3 is being read.
        i_imgLength = NB'(8);
        push_run(4, 3, 1, e0);
        i_run = 1'b1;
        while (cyc < e0 + 4) step();
        i_rst = 1'b1;
        i_run = 1'b0;
        step();
        chk("mid_rst_rd_en", o_rd_en, 0);
        chk("mid_rst_conv_valid", o_conv_valid, 0);
        chk("mid_rst_res_wr_en", o_res_wr_en, 0);
        chk("mid_rst_wr_en", o_wr_en, 0);
        chk("mid_rst_eop", o_EOP, 0);
        step();
        i_rst = 1'b0;
        steps(4);
        chk("mid_rst_rd_left", rd_q.size(), 0);
        chk("mid_rst_cv_left", cv_q.size(), 0);

        // Fresh run after reset.
        push_run(8, 8, 7, e0);
        i_run = 1'b1;
        wait_eop(e0 + 8 + LAT + 2, "rerun_eop");
        i_run = 1'b0;
        steps(3);
        chk("final_rd_left", rd_q.size(), 0);
        chk("final_cv_left", cv_q.size(), 0);
        chk("final_res_left", res_q.size(), 0);
        chk("final_wr_left", wr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
